// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the digit width, the FSM encoding and the parameter legality check.
package bcd_pkg;

   localparam int unsigned DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_e;

   // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value.
   function automatic bit digits_fit(int unsigned width, int unsigned digits);
      longint unsigned p10;
      longint unsigned max_bin;
      p10 = 64'd1;
      for (int unsigned i = 0; i < digits; i++) begin
         p10 = p10 * 64'd10;
      end
      max_bin = (64'd1 << width) - 64'd1;
      return p10 > max_bin;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_digit,
   output logic [DIGIT_W-1:0] o_digit
);

   always_comb begin
      o_digit = i_digit;
      if (i_digit >= DIGIT_W'(5)) begin
         o_digit = i_digit + DIGIT_W'(3);
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Digits are registered and change only on the cycle done pulses.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [WIDTH-1:0]            bin_in,
   output logic                        busy,
   output logic                        done,
   output logic [DIGITS*DIGIT_W-1:0]   bcd
);

   localparam int unsigned BCD_W = DIGITS * DIGIT_W;
   localparam int unsigned SCR_W = BCD_W + WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_params
      $error("bin_to_bcd_seq: DIGITS too small to represent 2**WIDTH-1");
   end

   state_e             r_state;
   logic [SCR_W-1:0]   r_scratch;
   logic [CNT_W-1:0]   r_count;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_done;

   logic [BCD_W-1:0]   w_adj;
   logic [SCR_W-1:0]   w_shifted;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3_digit u_add3 (
         .i_digit (r_scratch[WIDTH + g*DIGIT_W +: DIGIT_W]),
         .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   // Correction is applied to the digit field first, then everything shifts.
   assign w_shifted = {w_adj, r_scratch[WIDTH-1:0]} << 1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_scratch <= '0;
         r_count   <= '0;
         r_bcd     <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_scratch <= {{BCD_W{1'b0}}, bin_in};
                  r_count   <= '0;
                  r_state   <= SHIFT;
               end
            end
            SHIFT: begin
               r_scratch <= w_shifted;
               r_count   <= r_count + CNT_W'(1);
               if (r_count == CNT_W'(WIDTH - 1)) begin
                  r_state <= FINISH;
               end
            end
            FINISH: begin
               r_bcd   <= r_scratch[SCR_W-1 -: BCD_W];
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy = (r_state != IDLE);
   assign done = r_done;
   assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed and random conversions
// compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned DIGITS = 5;
   localparam int unsigned LAT    = WIDTH + 1;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [WIDTH-1:0]  bin_in;
   logic              busy;
   logic              done;
   logic [4*DIGITS-1:0] bcd;

   int total;
   int bad;

   bin_to_bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bin_in (bin_in),
      .busy   (busy),
      .done   (done),
      .bcd    (bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4*DIGITS-1:0] ref_bcd(int unsigned v);
      logic [4*DIGITS-1:0] r;
      int unsigned p;
      r = '0;
      p = 1;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; sample and drive 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full conversion with latency, busy and bcd checks.
   task automatic convert(input int unsigned v);
      int n;
      int busy_low;
      bin_in = WIDTH'(v);
      start  = 1'b1;
      tick();
      start  = 1'b0;
      n = 0;
      busy_low = 0;
      while (!done && n < 40) begin
         if (!busy) busy_low++;
         tick();
         n++;
      end
      check($sformatf("latency_%0d", v), n, LAT);
      check($sformatf("busy_during_%0d", v), busy_low, 0);
      check($sformatf("bcd_%0d", v), bcd, ref_bcd(v));
      check($sformatf("busy_at_done_%0d", v), busy, 0);
      tick();
      check($sformatf("done_pulse_%0d", v), done, 0);
   endtask

   initial begin
      int n;
      int dones;
      int first_done;
      int second_done;
      int hold_bad;
      int unsigned v;
      int unsigned dir[6] = '{460, 0, 65535, 9, 10, 9999};

      total  = 0;
      bad    = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      bin_in = '0;
      tick();
      tick();
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_bcd", bcd, 0);
      rst_n = 1'b1;
      tick();

      foreach (dir[i]) convert(dir[i]);
      for (int i = 0; i < 20; i++) begin
         v = $urandom_range(0, 65535);
         convert(v);
      end

      // Start and bin_in changes while busy are ignored.
      bin_in = 16'd5;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (4) tick();
      bin_in = 16'd77;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      dones = 0;
      for (int i = 0; i < 30; i++) begin
         if (done) dones++;
         tick();
      end
      check("busy_start_dones", dones, 1);
      check("busy_start_bcd", bcd, ref_bcd(5));

      // bcd holds the previous result while the next conversion runs.
      convert(1234);
      bin_in = 16'd42;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      n = 0;
      hold_bad = 0;
      while (!done && n < 40) begin
         if (bcd !== ref_bcd(1234)) hold_bad++;
         tick();
         n++;
      end
      check("hold_old_bcd", hold_bad, 0);
      check("hold_latency", n, LAT);
      check("hold_new_bcd", bcd, ref_bcd(42));

      // Back-to-back with start held high.
      tick();
      bin_in = 16'd100;
      start  = 1'b1;
      dones = 0;
      first_done = -1;
      second_done = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) begin
            dones++;
            if (first_done < 0) first_done = i;
            else if (second_done < 0) second_done = i;
         end
      end
      start = 1'b0;
      check("b2b_dones", dones, 2);
      check("b2b_spacing", second_done - first_done, WIDTH + 2);
      check("b2b_bcd", bcd, ref_bcd(100));
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      check("b2b_drain", busy, 0);
      tick();

      // Reset mid-conversion aborts and clears bcd.
      bin_in = 16'd999;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (7) tick();
      check("mid_busy_before_reset", busy, 1);
      rst_n = 1'b0;
      tick();
      check("mid_reset_busy", busy, 0);
      check("mid_reset_done", done, 0);
      check("mid_reset_bcd", bcd, 0);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         if (done) dones++;
         tick();
      end
      check("mid_reset_no_done", dones, 0);
      convert(321);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
